pkt_desc_gen: RTL

Parametrised packet-to-PDU generator on the RX path, between the flow-classification stage and the PCIe packet and descriptor buffers. It consumes an Avalon-ST packet stream and a per-packet metadata stream, and writes flits into the packet buffer and one descriptor per packet into the descriptor buffer. Compared with the previous generation it adds:
- configurable flit width;
- optional byte swap;
- whole-packet admission against reported buffer credits, so a packet never stalls mid-flight;
- descriptors carrying both byte and flit counts;
- metadata-directed drop;
- truncation of oversize packets;
- statistics counters.

---
 rtl/pkt_desc_gen.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_desc_gen.sv
// RX packet-to-PDU generator: admits whole packets against buffer credits, writes
// flits to the packet buffer and one descriptor per packet to the descriptor buffer.
module pkt_desc_gen #(
  parameter int DATA_WIDTH     = 512,
  parameter int EMPTY_WIDTH    = $clog2(DATA_WIDTH/8),
  parameter int MAX_PKT_FLITS  = 24,
  parameter int SIZE_WIDTH     = 16,
  parameter int APP_IDX_WIDTH  = 8,
  parameter int FLOW_IDX_WIDTH = 8,
  parameter int DSC_ID_WIDTH   = APP_IDX_WIDTH,
  parameter int PKT_ID_WIDTH   = FLOW_IDX_WIDTH,
  parameter int SWAP_BYTES     = 1,
  parameter int CREDIT_WIDTH   = 16,
  localparam int FLIT_CNT_WIDTH = $clog2(MAX_PKT_FLITS+1)
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [EMPTY_WIDTH-1:0]    in_empty,
  input  logic                      in_valid,
  output logic                      in_ready,

  input  logic [DSC_ID_WIDTH-1:0]   in_meta_dsc_queue_id,
  input  logic [PKT_ID_WIDTH-1:0]   in_meta_pkt_queue_id,
  input  logic                      in_meta_drop,
  input  logic                      in_meta_valid,
  output logic                      in_meta_ready,

  output logic [DATA_WIDTH-1:0]     pkt_buf_wr_data,
  output logic                      pkt_buf_wr_sop,
  output logic                      pkt_buf_wr_eop,
  output logic                      pkt_buf_wr_en,
  input  logic [CREDIT_WIDTH-1:0]   pkt_buf_free,

  output logic [DSC_ID_WIDTH-1:0]   desc_buf_wr_dsc_queue_id,
  output logic [PKT_ID_WIDTH-1:0]   desc_buf_wr_pkt_queue_id,
  output logic [SIZE_WIDTH-1:0]     desc_buf_wr_bytes,
  output logic [FLIT_CNT_WIDTH-1:0] desc_buf_wr_flits,
  output logic                      desc_buf_wr_trunc,
  output logic                      desc_buf_wr_en,
  input  logic [CREDIT_WIDTH-1:0]   desc_buf_free,

  output logic [31:0]               stat_pkts,
  output logic [31:0]               stat_drops,
  output logic [31:0]               stat_truncs,
  output logic [31:0]               stat_orphans
);

  localparam int unsigned BPF    = DATA_WIDTH / 8;
  localparam int          PROD_W = SIZE_WIDTH + FLIT_CNT_WIDTH + $clog2(BPF + 1) + 1;

  localparam logic [CREDIT_WIDTH-1:0]   PKT_CRED_MIN = CREDIT_WIDTH'(MAX_PKT_FLITS + 2);
  localparam logic [CREDIT_WIDTH-1:0]   DSC_CRED_MIN = CREDIT_WIDTH'(2);
  localparam logic [FLIT_CNT_WIDTH-1:0] MAX_CNT      = FLIT_CNT_WIDTH'(MAX_PKT_FLITS);

  typedef enum logic [1:0] {IDLE, FWD, DISCARD} state_e;

  state_e                    state_q;
  logic [FLIT_CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
  logic                      drop_pend_q;
  logic [DSC_ID_WIDTH-1:0]   dsc_id_q;
  logic [PKT_ID_WIDTH-1:0]   pkt_id_q;

  logic [DATA_WIDTH-1:0]     wr_data_q;
  logic                      wr_sop_q, wr_eop_q, wr_en_q;
  logic [DSC_ID_WIDTH-1:0]   d_dsc_q;
  logic [PKT_ID_WIDTH-1:0]   d_pkt_q;
  logic [SIZE_WIDTH-1:0]     d_bytes_q;
  logic [FLIT_CNT_WIDTH-1:0] d_flits_q;
  logic                      d_trunc_q, d_en_q, meta_ready_q;
  logic [31:0]               st_pkts_q, st_drops_q, st_truncs_q, st_orph_q;

  logic                      cred_ok, ready_c, accept, write_flit, pkt_end;
  logic [DATA_WIDTH-1:0]     swapped;
  logic [PROD_W-1:0]         prod;
  logic [SIZE_WIDTH-1:0]     bytes_sat;
  logic [DSC_ID_WIDTH-1:0]   dsc_sel;
  logic [PKT_ID_WIDTH-1:0]   pkt_sel;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign cred_ok = (pkt_buf_free >= PKT_CRED_MIN) && (desc_buf_free >= DSC_CRED_MIN);

  always_comb begin
    ready_c = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    ready_c = !in_sop || (in_meta_valid && (in_meta_drop || cred_ok));
        default: ready_c = 1'b1;
      endcase
    end
  end

  assign accept     = in_valid && ready_c;
  assign write_flit = accept && ((state_q == FWD) || (state_q == IDLE && in_sop && !in_meta_drop));
  assign flit_cnt_d = (state_q == IDLE) ? FLIT_CNT_WIDTH'(1) : flit_cnt_q + 1'b1;
  assign pkt_end    = in_eop || (flit_cnt_d == MAX_CNT);

  // Metadata is only registered on the sop write, so that cycle's descriptor takes it straight from the input
  assign dsc_sel = (state_q == IDLE) ? in_meta_dsc_queue_id : dsc_id_q;
  assign pkt_sel = (state_q == IDLE) ? in_meta_pkt_queue_id : pkt_id_q;

  always_comb begin
    swapped = '0;
    for (int unsigned b = 0; b < BPF; b++) begin
      if (SWAP_BYTES != 0) swapped[8*b +: 8] = in_data[8*(BPF-1-b) +: 8];
      else                 swapped[8*b +: 8] = in_data[8*b +: 8];
    end
  end

  // Truncated packets count every flit as full; empty only applies on a natural eop
  always_comb begin
    prod = PROD_W'(flit_cnt_d) * PROD_W'(BPF);
    if (in_eop) prod = prod - PROD_W'(in_empty);
    bytes_sat = (|prod[PROD_W-1:SIZE_WIDTH]) ? '1 : prod[SIZE_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flit_cnt_q   <= '0;
      drop_pend_q  <= 1'b0;
      dsc_id_q     <= '0;
      pkt_id_q     <= '0;
      wr_data_q    <= '0;
      wr_sop_q     <= 1'b0;
      wr_eop_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      d_dsc_q      <= '0;
      d_pkt_q      <= '0;
      d_bytes_q    <= '0;
      d_flits_q    <= '0;
      d_trunc_q    <= 1'b0;
      d_en_q       <= 1'b0;
      meta_ready_q <= 1'b0;
      st_pkts_q    <= '0;
      st_drops_q   <= '0;
      st_truncs_q  <= '0;
      st_orph_q    <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      wr_sop_q     <= 1'b0;
      wr_eop_q     <= 1'b0;
      d_en_q       <= 1'b0;
      d_trunc_q    <= 1'b0;
      meta_ready_q <= 1'b0;

      if (write_flit) begin
        wr_en_q    <= 1'b1;
        wr_data_q  <= swapped;
        wr_sop_q   <= (state_q == IDLE);
        flit_cnt_q <= flit_cnt_d;
        if (state_q == IDLE) begin
          dsc_id_q <= in_meta_dsc_queue_id;
          pkt_id_q <= in_meta_pkt_queue_id;
        end
        if (pkt_end) begin
          wr_eop_q     <= 1'b1;
          d_en_q       <= 1'b1;
          d_dsc_q      <= dsc_sel;
          d_pkt_q      <= pkt_sel;
          d_bytes_q    <= bytes_sat;
          d_flits_q    <= flit_cnt_d;
          d_trunc_q    <= !in_eop;
          meta_ready_q <= 1'b1;
          st_pkts_q    <= sat_inc(st_pkts_q);
          if (in_eop) begin
            state_q <= IDLE;
          end else begin
            state_q     <= DISCARD;
            drop_pend_q <= 1'b0;
            st_truncs_q <= sat_inc(st_truncs_q);
          end
        end else begin
          state_q <= FWD;
        end
      end else if (accept) begin
        case (state_q)
          IDLE: begin
            if (!in_sop) begin
              st_orph_q <= sat_inc(st_orph_q);
            end else if (in_eop) begin
              meta_ready_q <= 1'b1;
              st_drops_q   <= sat_inc(st_drops_q);
            end else begin
              state_q     <= DISCARD;
              drop_pend_q <= 1'b1;
            end
          end
          DISCARD: begin
            if (in_eop) begin
              state_q     <= IDLE;
              drop_pend_q <= 1'b0;
              if (drop_pend_q) begin
                meta_ready_q <= 1'b1;
                st_drops_q   <= sat_inc(st_drops_q);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready                 = ready_c;
  assign in_meta_ready            = meta_ready_q;
  assign pkt_buf_wr_data          = wr_data_q;
  assign pkt_buf_wr_sop           = wr_sop_q;
  assign pkt_buf_wr_eop           = wr_eop_q;
  assign pkt_buf_wr_en            = wr_en_q;
  assign desc_buf_wr_dsc_queue_id = d_dsc_q;
  assign desc_buf_wr_pkt_queue_id = d_pkt_q;
  assign desc_buf_wr_bytes        = d_bytes_q;
  assign desc_buf_wr_flits        = d_flits_q;
  assign desc_buf_wr_trunc        = d_trunc_q;
  assign desc_buf_wr_en           = d_en_q;
  assign stat_pkts                = st_pkts_q;
  assign stat_drops               = st_drops_q;
  assign stat_truncs              = st_truncs_q;
  assign stat_orphans             = st_orph_q;

endmodule
